mbist_err_capture: RTL
======================

MBIST_ERR_CAPTURE -- requirements
Module: mbist_err_capture

Interface
REQ-001 SHALL have parameter BIST_ADDR_WD, default 9, meaning memory address width.
REQ-002 SHALL have parameter BIST_DATA_WD, default 32, meaning memory data width.
REQ-003 SHALL have parameter BIST_ERR_LIMIT, default 4 (legal range 1..15), meaning the number of unique failing addresses the downstream repair stage can absorb.
REQ-004 SHALL use one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- bist_start  in  1  one-cycle pulse: clear results, enter RUN.
- bist_done  in  1  one-cycle pulse: end of test.
- rd_valid  in  1  read issued this cycle.
- rd_addr  in  BIST_ADDR_WD  address of the issued read.
- exp_data  in  BIST_DATA_WD  expected data for the issued read.
- mem_rdata  in  BIST_DATA_WD  memory read data, valid exactly 1 cycle after rd_valid.
- Error  out  1  one-cycle pulse: new unique failing address.
- ErrorAddr  out  BIST_ADDR_WD  failing address, valid with Error, held otherwise.
- err_cnt  out  4  count of unique failing addresses reported.
- bist_fail  out  1  sticky: unique failures exceeded BIST_ERR_LIMIT.
- bist_busy  out  1  high in state RUN.

Function
REQ-006 SHALL implement states IDLE, RUN, FAIL; bist_busy = (state==RUN).
REQ-007 IDLE->RUN on bist_start; RUN->IDLE on bist_done; RUN->FAIL on overflow (REQ-013); FAIL->RUN on bist_start only; bist_done in IDLE/FAIL SHALL be ignored.
REQ-008 bist_start in any state SHALL clear err_cnt, bist_fail, the address table, and both pipeline valid stages in the same edge; it SHALL win over a simultaneous bist_done.
REQ-009 Stage 1 (cycle T): when rd_valid=1 and state==RUN and bist_start=0, SHALL register rd_addr, exp_data and a valid bit; reads outside RUN or in the bist_start cycle SHALL be dropped.
REQ-010 Stage 2 (cycle T+1): SHALL compare mem_rdata against registered exp_data (full-width, bitwise); a mismatch with a valid stage-1 entry is a candidate.
REQ-011 A candidate whose address matches any of the first err_cnt table entries SHALL be suppressed (no Error, no count change).
REQ-012 A new candidate with err_cnt < BIST_ERR_LIMIT SHALL, at the T+2 edge, pulse Error for exactly one cycle, drive ErrorAddr = address, store it in table[err_cnt], and increment err_cnt.
REQ-013 A new candidate with err_cnt == BIST_ERR_LIMIT SHALL set bist_fail and move to FAIL; no Error pulse, err_cnt SHALL saturate at BIST_ERR_LIMIT.
REQ-014 Stage-1 entries captured before bist_done SHALL complete their compare (pipeline drain) even though state is now IDLE; Error may pulse one cycle after leaving RUN.
REQ-015 In FAIL, new reads SHALL be dropped; the in-flight stage-1 entry SHALL not alter outputs.
REQ-016 Back-to-back rd_valid every cycle SHALL be supported at full throughput; consecutive unique failures SHALL produce consecutive Error pulses.
REQ-017 Two consecutive candidates at the same new address SHALL yield one Error only (table update visible to the next compare).
REQ-018 Results (err_cnt, bist_fail, ErrorAddr, table) SHALL hold in IDLE until the next bist_start.

Reset
REQ-019 On rst_n low: state=IDLE, Error=0, ErrorAddr=0, err_cnt=0, bist_fail=0, bist_busy=0, pipeline valids=0, table cleared; asserted mid-RUN SHALL abort immediately with no further Error pulses.

Verification
REQ-020 start; reads addr 0x000..0x00F all matching; done -> Error never pulses, err_cnt=0, bist_fail=0, bist_busy 0 after done.
REQ-021 start; read 0x005 with mem_rdata=exp_data^0x1 -> Error pulses 2 cycles after rd_valid, ErrorAddr=0x005, err_cnt=1.
REQ-022 start; failing reads at 0x005 three times (back-to-back and spaced) -> single Error pulse, err_cnt=1.
REQ-023 Limit 4; unique failures at 0x010,0x011,0x012,0x013,0x014 -> four Error pulses, fifth gives bist_fail=1, state FAIL, err_cnt=4, no fifth pulse.
REQ-024 Failing read in the last RUN cycle with bist_done same cycle -> Error still pulses after IDLE entry, ErrorAddr correct; bist_start together with bist_done and rd_valid -> counters cleared, read dropped, state RUN.
REQ-025 rst_n low one cycle after a failing rd_valid -> no Error pulse, all outputs at reset values.

Source files
------------

// File: rtl/mbist_err_capture.sv
// MBIST error capture: two-stage read compare with a small table of unique failing
// addresses, one Error pulse per new address, and overflow detection past BIST_ERR_LIMIT.
module mbist_err_capture #(
  parameter int          BIST_ADDR_WD   = 9,
  parameter int          BIST_DATA_WD   = 32,
  parameter int unsigned BIST_ERR_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bist_start,
  input  logic                    bist_done,
  input  logic                    rd_valid,
  input  logic [BIST_ADDR_WD-1:0] rd_addr,
  input  logic [BIST_DATA_WD-1:0] exp_data,
  input  logic [BIST_DATA_WD-1:0] mem_rdata,
  output logic                    Error,
  output logic [BIST_ADDR_WD-1:0] ErrorAddr,
  output logic [3:0]              err_cnt,
  output logic                    bist_fail,
  output logic                    bist_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  localparam logic [3:0] LIMIT = 4'(BIST_ERR_LIMIT);

  logic [1:0]              state;
  logic                    s1_valid;
  logic [BIST_ADDR_WD-1:0] s1_addr;
  logic [BIST_DATA_WD-1:0] s1_exp;
  logic [BIST_ADDR_WD-1:0] tbl [BIST_ERR_LIMIT];
  logic [3:0]              cnt;

  logic capture;
  logic hit;
  logic candidate;
  logic fresh;
  logic log_err;
  logic overflow;

  // Reads are only accepted while running; the start cycle drops them.
  assign capture = rd_valid && (state == ST_RUN) && !bist_start;

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < BIST_ERR_LIMIT; i++) begin
      if ((4'(i) < cnt) && (tbl[i] == s1_addr)) hit = 1'b1;
    end
  end

  // Entries still draining after bist_done are compared in IDLE; FAIL ignores them.
  assign candidate = s1_valid && (state != ST_FAIL) && (mem_rdata != s1_exp);
  assign fresh     = candidate && !hit && !bist_start;
  assign log_err   = fresh && (cnt < LIMIT);
  assign overflow  = fresh && (cnt >= LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (bist_start) begin
      state <= ST_RUN;
    end else if (state == ST_RUN) begin
      if (overflow)       state <= ST_FAIL;
      else if (bist_done) state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_exp   <= '0;
    end else begin
      s1_valid <= capture;
      if (capture) begin
        s1_addr <= rd_addr;
        s1_exp  <= exp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Error     <= 1'b0;
      ErrorAddr <= '0;
      cnt       <= '0;
      bist_fail <= 1'b0;
    end else if (bist_start) begin
      Error     <= 1'b0;
      cnt       <= '0;
      bist_fail <= 1'b0;
    end else begin
      Error <= log_err;
      if (log_err) begin
        ErrorAddr <= s1_addr;
        cnt       <= cnt + 4'd1;
      end
      if (overflow) bist_fail <= 1'b1;
    end
  end

  // Table slot written is the current count, so the next compare already sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BIST_ERR_LIMIT; i++) tbl[i] <= '0;
    end else if (bist_start) begin
      for (int unsigned i = 0; i < BIST_ERR_LIMIT; i++) tbl[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < BIST_ERR_LIMIT; i++) begin
        if (log_err && (4'(i) == cnt)) tbl[i] <= s1_addr;
      end
    end
  end

  assign err_cnt   = cnt;
  assign bist_busy = (state == ST_RUN);

endmodule
